// File: rtl/ram_arb_pkg.sv
// Shared widths and state encoding for the external-RAM arbiter.
// Imported by the interface, the round-robin picker and the top level.
package ram_arb_pkg;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   // A two-port arbiter still needs a one-bit pointer.
   function automatic int ptr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// External RAM port: enable-until-busy strobes out, busy and read-data handshake back.
// The master side is the arbiter; the slave side is the RAM controller.
interface ram_arbiter_if;
   import ram_arb_pkg::*;

   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_enable;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_enable;
   logic              busy;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ready;

   modport master (
      output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
      input  busy, rd_data, rd_ready
   );

   modport slave (
      input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
      output busy, rd_data, rd_ready
   );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid port after i_ptr, wrapping modulo N_REQ.
// The last-granted port has lowest priority on the next pick.
module rr_picker
   import ram_arb_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int PTR_W = ptr_width(N_REQ)
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic             o_any,
   output logic [PTR_W-1:0] o_grant
);

   logic [PTR_W-1:0] w_idx;

   // Scan farthest offset first so the nearest valid port overwrites it.
   always_comb begin
      o_any   = 1'b0;
      o_grant = '0;
      w_idx   = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         w_idx = PTR_W'((int'(i_ptr) + i) % N_REQ);
         if (i_valid[w_idx]) begin
            o_any   = 1'b1;
            o_grant = w_idx;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one external RAM port among N_REQ requesters,
// one transaction in flight, with per-port done/err pulses and a watchdog timer.
//
// state   | meaning
// IDLE    | waiting for a request while RAM is not busy
// ISSUE   | enable strobe held until RAM raises busy
// WAIT_RD | read accepted, waiting for rd_ready
// RELEASE | one-cycle gap; requester drops valid here
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 256
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ-1:0]        i_req_we,
   input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
   input  logic [N_REQ*DATA_W-1:0] i_req_wdata,
   output logic [N_REQ-1:0]        o_req_done,
   output logic [N_REQ-1:0]        o_req_err,
   output logic [DATA_W-1:0]       o_req_rdata,
   ram_arbiter_if.master           ram
);

   localparam int               PTR_W    = ptr_width(N_REQ);
   localparam int               TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

   arb_state_t        r_state, w_state_nxt;
   logic [PTR_W-1:0]  r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0]  r_grant, w_grant_nxt;
   logic              r_we, w_we_nxt;
   logic [TMR_W-1:0]  r_timer, w_timer_nxt;
   logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
   logic              r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
   logic              r_rd_en, w_rd_en_nxt;
   logic [N_REQ-1:0]  r_done, w_done_nxt;
   logic [N_REQ-1:0]  r_err, w_err_nxt;
   logic [DATA_W-1:0] r_rdata, w_rdata_nxt;

   logic              w_any;
   logic [PTR_W-1:0]  w_pick;
   logic [N_REQ-1:0]  w_grant_oh;
   logic              w_tmo;

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .i_valid (i_req_valid),
      .i_ptr   (r_ptr),
      .o_any   (w_any),
      .o_grant (w_pick)
   );

   assign w_grant_oh = ONE << r_grant;
   assign w_tmo      = (r_timer == TMR_LAST);

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_grant_nxt   = r_grant;
      w_we_nxt      = r_we;
      w_timer_nxt   = r_timer;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_wr_en_nxt   = r_wr_en;
      w_rd_addr_nxt = r_rd_addr;
      w_rd_en_nxt   = r_rd_en;
      w_done_nxt    = '0;
      w_err_nxt     = '0;
      w_rdata_nxt   = r_rdata;

      case (r_state)
         IDLE: begin
            if (!ram.busy && w_any) begin
               w_grant_nxt = w_pick;
               w_ptr_nxt   = w_pick;
               w_we_nxt    = i_req_we[w_pick];
               w_timer_nxt = '0;
               w_state_nxt = ISSUE;
               if (i_req_we[w_pick]) begin
                  w_wr_addr_nxt = i_req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                  w_wr_data_nxt = i_req_wdata[int'(w_pick)*DATA_W +: DATA_W];
                  w_wr_en_nxt   = 1'b1;
               end else begin
                  w_rd_addr_nxt = i_req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                  w_rd_en_nxt   = 1'b1;
               end
            end
         end
         ISSUE: begin
            // A completion seen on the last timer cycle wins over the abort.
            if (ram.busy && r_we) begin
               w_wr_en_nxt = 1'b0;
               w_done_nxt  = w_grant_oh;
               w_state_nxt = RELEASE;
            end else if (ram.busy && ram.rd_ready) begin
               w_rd_en_nxt = 1'b0;
               w_rdata_nxt = ram.rd_data;
               w_done_nxt  = w_grant_oh;
               w_state_nxt = RELEASE;
            end else if (w_tmo) begin
               w_wr_en_nxt = 1'b0;
               w_rd_en_nxt = 1'b0;
               w_err_nxt   = w_grant_oh;
               w_state_nxt = RELEASE;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
               if (ram.busy) begin
                  w_rd_en_nxt = 1'b0;
                  w_state_nxt = WAIT_RD;
               end
            end
         end
         WAIT_RD: begin
            if (ram.rd_ready) begin
               w_rdata_nxt = ram.rd_data;
               w_done_nxt  = w_grant_oh;
               w_state_nxt = RELEASE;
            end else if (w_tmo) begin
               w_wr_en_nxt = 1'b0;
               w_rd_en_nxt = 1'b0;
               w_err_nxt   = w_grant_oh;
               w_state_nxt = RELEASE;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         RELEASE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_ptr     <= PTR_W'(N_REQ - 1);
         r_grant   <= '0;
         r_we      <= 1'b0;
         r_timer   <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_en   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_en   <= 1'b0;
         r_done    <= '0;
         r_err     <= '0;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_grant   <= w_grant_nxt;
         r_we      <= w_we_nxt;
         r_timer   <= w_timer_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_rd_addr <= w_rd_addr_nxt;
         r_rd_en   <= w_rd_en_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_rdata   <= w_rdata_nxt;
      end
   end

   assign o_req_done    = r_done;
   assign o_req_err     = r_err;
   assign o_req_rdata   = r_rdata;
   assign ram.wr_addr   = r_wr_addr;
   assign ram.wr_data   = r_wr_data;
   assign ram.wr_enable = r_wr_en;
   assign ram.rd_addr   = r_rd_addr;
   assign ram.rd_enable = r_rd_en;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: the bench plays the RAM side cycle by cycle
// and checks registered outputs 1 time unit after each rising edge.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_we;
   logic [71:0] req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  req_done;
   logic [2:0]  req_err;
   logic [15:0] req_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_arbiter_if ram_if ();

   ram_arbiter #(
      .N_REQ   (3),
      .TIMEOUT (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_we    (req_we),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_req_done  (req_done),
      .o_req_err   (req_err),
      .o_req_rdata (req_rdata),
      .ram         (ram_if)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"},  32'(req_done),         32'h0);
      chk({tag, "_err"},   32'(req_err),          32'h0);
      chk({tag, "_rdata"}, 32'(req_rdata),        32'h0);
      chk({tag, "_wr_en"}, 32'(ram_if.wr_enable), 32'h0);
      chk({tag, "_rd_en"}, 32'(ram_if.rd_enable), 32'h0);
      chk({tag, "_wr_a"},  32'(ram_if.wr_addr),   32'h0);
      chk({tag, "_wr_d"},  32'(ram_if.wr_data),   32'h0);
      chk({tag, "_rd_a"},  32'(ram_if.rd_addr),   32'h0);
   endtask

   initial begin
      rst              = 1'b1;
      req_valid        = '0;
      req_we           = '0;
      req_addr         = '0;
      req_wdata        = '0;
      ram_if.busy      = 1'b0;
      ram_if.rd_data   = '0;
      ram_if.rd_ready  = 1'b0;
      step;
      step;
      chk_zero("reset");
      rst = 1'b0;

      // 1: single write from port 1; busy arrives after enable has been up one cycle
      req_valid               = 3'b010;
      req_we                  = 3'b010;
      req_addr[1*24 +: 24]    = 24'h123456;
      req_wdata[1*16 +: 16]   = 16'hBEEF;
      step;
      chk("t1_wr_en_c1", 32'(ram_if.wr_enable), 32'd1);
      chk("t1_wr_addr",  32'(ram_if.wr_addr),   32'h123456);
      chk("t1_wr_data",  32'(ram_if.wr_data),   32'hBEEF);
      step;
      chk("t1_wr_en_c2", 32'(ram_if.wr_enable), 32'd1);
      chk("t1_no_done",  32'(req_done),         32'h0);
      ram_if.busy = 1'b1;
      step;
      chk("t1_wr_en_off", 32'(ram_if.wr_enable), 32'd0);
      chk("t1_done",      32'(req_done),         32'b010);
      chk("t1_err",       32'(req_err),          32'h0);
      chk("t1_rd_en",     32'(ram_if.rd_enable), 32'd0);
      req_valid   = 3'b000;
      ram_if.busy = 1'b0;
      step;
      chk("t1_done_pulse", 32'(req_done),       32'h0);
      chk("t1_addr_hold",  32'(ram_if.wr_addr), 32'h123456);

      // 2: read from port 0, rd_ready three cycles after busy
      req_valid            = 3'b001;
      req_we               = 3'b000;
      req_addr[0*24 +: 24] = 24'h000010;
      step;
      chk("t2_rd_en",   32'(ram_if.rd_enable), 32'd1);
      chk("t2_rd_addr", 32'(ram_if.rd_addr),   32'h000010);
      chk("t2_wr_en",   32'(ram_if.wr_enable), 32'd0);
      ram_if.busy = 1'b1;
      step;
      chk("t2_rd_en_off", 32'(ram_if.rd_enable), 32'd0);
      chk("t2_no_done_a", 32'(req_done),         32'h0);
      step;
      chk("t2_no_done_b", 32'(req_done),         32'h0);
      step;
      ram_if.rd_ready = 1'b1;
      ram_if.rd_data  = 16'hA5A5;
      ram_if.busy     = 1'b0;
      step;
      chk("t2_done",  32'(req_done),  32'b001);
      chk("t2_rdata", 32'(req_rdata), 32'hA5A5);
      ram_if.rd_ready = 1'b0;
      ram_if.rd_data  = 16'h0000;
      req_valid       = 3'b000;
      step;
      chk("t2_done_pulse", 32'(req_done),  32'h0);
      chk("t2_rdata_hold", 32'(req_rdata), 32'hA5A5);

      // 4: read from port 2 where busy and rd_ready coincide
      req_valid            = 3'b100;
      req_addr[2*24 +: 24] = 24'h00ABCD;
      step;
      chk("t4_rd_en",   32'(ram_if.rd_enable), 32'd1);
      chk("t4_rd_addr", 32'(ram_if.rd_addr),   32'h00ABCD);
      ram_if.busy     = 1'b1;
      ram_if.rd_ready = 1'b1;
      ram_if.rd_data  = 16'h1234;
      step;
      chk("t4_done",      32'(req_done),         32'b100);
      chk("t4_rdata",     32'(req_rdata),        32'h1234);
      chk("t4_rd_en_off", 32'(ram_if.rd_enable), 32'd0);
      ram_if.busy     = 1'b0;
      ram_if.rd_ready = 1'b0;
      req_valid       = 3'b000;
      step;
      chk("t4_done_pulse", 32'(req_done), 32'h0);

      // 3: fresh reset, all three ports write continuously
      rst = 1'b1;
      step;
      chk_zero("t3_reset");
      rst                  = 1'b0;
      req_we               = 3'b111;
      req_addr[0*24 +: 24] = 24'h000100;
      req_addr[1*24 +: 24] = 24'h000101;
      req_addr[2*24 +: 24] = 24'h000102;
      req_valid            = 3'b111;
      for (int k = 0; k < 6; k++) begin
         step;
         chk("t3_wr_en",   32'(ram_if.wr_enable), 32'd1);
         chk("t3_wr_addr", 32'(ram_if.wr_addr),   32'(24'h000100 + k % 3));
         ram_if.busy = 1'b1;
         step;
         chk("t3_done", 32'(req_done), 32'(3'b001 << (k % 3)));
         ram_if.busy = 1'b0;
         step;
         chk("t3_release", 32'(req_done),         32'h0);
         chk("t3_en_low",  32'(ram_if.wr_enable), 32'd0);
      end

      // 5: busy never rises; TIMEOUT=8 aborts port 0, then port 1 is served
      req_we               = 3'b000;
      req_addr[0*24 +: 24] = 24'h000777;
      req_addr[1*24 +: 24] = 24'h000888;
      req_valid            = 3'b011;
      step;
      chk("t5_rd_en_c0",   32'(ram_if.rd_enable), 32'd1);
      chk("t5_rd_addr_p0", 32'(ram_if.rd_addr),   32'h000777);
      for (int k = 1; k < 8; k++) begin
         step;
         chk("t5_rd_en_hold", 32'(ram_if.rd_enable), 32'd1);
         chk("t5_no_err",     32'(req_err),          32'h0);
      end
      step;
      chk("t5_rd_en_off", 32'(ram_if.rd_enable), 32'd0);
      chk("t5_err",       32'(req_err),          32'b001);
      chk("t5_no_done",   32'(req_done),         32'h0);
      chk("t5_rdata",     32'(req_rdata),        32'h0);
      req_valid = 3'b010;
      step;
      chk("t5_err_pulse", 32'(req_err), 32'h0);
      step;
      chk("t5_next_rd_en",   32'(ram_if.rd_enable), 32'd1);
      chk("t5_next_rd_addr", 32'(ram_if.rd_addr),   32'h000888);
      ram_if.busy     = 1'b1;
      ram_if.rd_ready = 1'b1;
      ram_if.rd_data  = 16'h5555;
      step;
      chk("t5_next_done",  32'(req_done),  32'b010);
      chk("t5_next_rdata", 32'(req_rdata), 32'h5555);
      ram_if.busy     = 1'b0;
      ram_if.rd_ready = 1'b0;
      req_valid       = 3'b000;
      step;

      // 6: reset while waiting for read data from port 2
      req_addr[2*24 +: 24] = 24'h0000FE;
      req_valid            = 3'b100;
      step;
      chk("t6_rd_en",   32'(ram_if.rd_enable), 32'd1);
      chk("t6_rd_addr", 32'(ram_if.rd_addr),   32'h0000FE);
      ram_if.busy = 1'b1;
      step;
      chk("t6_wait_rd", 32'(ram_if.rd_enable), 32'd0);
      rst         = 1'b1;
      ram_if.busy = 1'b0;
      step;
      chk_zero("t6_reset");
      rst                  = 1'b0;
      req_addr[0*24 +: 24] = 24'h000ABC;
      req_valid            = 3'b111;
      step;
      chk("t6_p0_rd_en",   32'(ram_if.rd_enable), 32'd1);
      chk("t6_p0_rd_addr", 32'(ram_if.rd_addr),   32'h000ABC);
      ram_if.busy     = 1'b1;
      ram_if.rd_ready = 1'b1;
      ram_if.rd_data  = 16'h0F0F;
      step;
      chk("t6_p0_done",  32'(req_done),  32'b001);
      chk("t6_p0_rdata", 32'(req_rdata), 32'h0F0F);
      ram_if.busy     = 1'b0;
      ram_if.rd_ready = 1'b0;
      req_valid       = 3'b000;
      step;
      chk("t6_done_pulse", 32'(req_done), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
